// File: rtl/linear_layer_scheduler_pkg.sv
// Package linear_pkg: shared types and helpers for linear_layer_scheduler.
//   state_e : scheduler FSM states
//   acc_t   : signed accumulator/result type at the default BIAS_PRECISION
//   cnt_w() : width of a counter holding values 0..n-1 (never less than 1)
package linear_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CLEAR   = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4,
        SUM     = 3'd5,
        OUT     = 3'd6
    } state_e;

    localparam int ACC_W = 32;
    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic int cnt_w(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/linear_layer_scheduler_lane_reducer.sv
// lane_reducer: registered signed sum of LANES accumulator lanes.
// The sum wraps modulo 2^WIDTH. With LINEAR_SCHED_RELU_EN defined, a negative
// sum is stored as zero.
// Ports:
//   clk, rst_n : clock, async active-low reset (result clears to 0)
//   en         : capture the reduced sum this cycle
//   lanes      : LANES*WIDTH packed lanes, lane l at [l*WIDTH +: WIDTH]
//   result     : registered reduced value, held while en is low
module lane_reducer
    import linear_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [LANES*WIDTH-1:0] lanes,
    output logic [WIDTH-1:0]       result
);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] final_s;
    logic [WIDTH-1:0] result_r;

    // Wrapped two's-complement sum of all lanes plus optional clamp.
    always_comb begin
        sum_s = {WIDTH{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            sum_s = sum_s + lanes[l*WIDTH +: WIDTH];
        end
`ifdef LINEAR_SCHED_RELU_EN
        if (sum_s[WIDTH-1]) begin
            final_s = {WIDTH{1'b0}};
        end else begin
            final_s = sum_s;
        end
`else
        final_s = sum_s;
`endif
    end

    // Result register, loaded only on en so it stays stable while waiting downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
        end else if (en) begin
            result_r <= final_s;
        end else begin
            result_r <= result_r;
        end
    end

    assign result = result_r;

endmodule

// File: rtl/linear_layer_scheduler.sv
// linear_layer_scheduler: sequences one fully-connected layer over a multiplier array.
// Buffers one sample of NUM_CHUNKS feature chunks, replays it once per output neuron
// while reading weights (1-cycle latency), drives mul_rst/mul_ce, waits out the
// multiplier latency, reduces the accumulator lanes and emits one result per neuron.
// Optional build macro: LINEAR_SCHED_RELU_EN (results clamp negative sums to zero).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready/in_features feature chunk stream (accepted only while loading)
//   w_addr/w_rd_en/w_rd_data      weight memory, address = neuron*NUM_CHUNKS+chunk
//   mul_rst/mul_ce                multiplier accumulator clear and clock enable
//   mul_features/mul_weights      operands presented to the multiplier array
//   mul_acc                       MUL_PER_FEATURE accumulator lanes from the array
//   out_valid/out_ready/out_data/out_last  neuron result stream
module linear_layer_scheduler
    import linear_pkg::*;
#(
    parameter int NUM_FEATURES    = 4,
    parameter int PRECISION       = 8,
    parameter int BIAS_PRECISION  = 32,
    parameter int MUL_PER_FEATURE = 4,
    parameter int NUM_CHUNKS      = 8,
    parameter int NUM_NEURONS     = 16,
    parameter int MUL_LATENCY     = 3
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [NUM_FEATURES*PRECISION-1:0]          in_features,
    output logic [cnt_w(NUM_NEURONS*NUM_CHUNKS)-1:0]   w_addr,
    output logic                                       w_rd_en,
    input  logic [NUM_FEATURES*PRECISION-1:0]          w_rd_data,
    output logic                                       mul_rst,
    output logic                                       mul_ce,
    output logic [NUM_FEATURES*PRECISION-1:0]          mul_features,
    output logic [NUM_FEATURES*PRECISION-1:0]          mul_weights,
    input  logic [MUL_PER_FEATURE*BIAS_PRECISION-1:0]  mul_acc,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [BIAS_PRECISION-1:0]                  out_data,
    output logic                                       out_last
);

    localparam int CW  = cnt_w(NUM_CHUNKS);
    localparam int NW  = cnt_w(NUM_NEURONS);
    localparam int DW  = cnt_w(MUL_LATENCY + 1);
    localparam int AW  = cnt_w(NUM_NEURONS * NUM_CHUNKS);
    localparam int CHW = NUM_FEATURES * PRECISION;

    state_e          state_r;
    state_e          next_s;
    logic [CW-1:0]   chunk_r;
    logic [NW-1:0]   neuron_r;
    logic [DW-1:0]   drain_r;
    logic [CHW-1:0]  buf_r [NUM_CHUNKS];
    logic [CHW-1:0]  feat_r;
    logic            in_ready_r;
    logic            w_rd_en_r;
    logic            mul_ce_r;
    logic            mul_rst_r;
    logic            out_valid_r;
    logic            out_last_r;
    logic            last_chunk_s;
    logic            last_neuron_s;
    logic            in_fire_s;
    logic            out_fire_s;

    assign last_chunk_s  = (chunk_r == CW'(NUM_CHUNKS - 1));
    assign last_neuron_s = (neuron_r == NW'(NUM_NEURONS - 1));
    assign in_fire_s     = (state_r == LOAD) && in_valid && in_ready_r;
    assign out_fire_s    = (state_r == OUT) && out_valid_r && out_ready;

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:    next_s = LOAD;
            LOAD: begin
                if (in_fire_s && last_chunk_s) begin
                    next_s = CLEAR;
                end else begin
                    next_s = LOAD;
                end
            end
            CLEAR:   next_s = COMPUTE;
            COMPUTE: begin
                if (last_chunk_s) begin
                    next_s = DRAIN;
                end else begin
                    next_s = COMPUTE;
                end
            end
            DRAIN: begin
                // Entry cycle carries the final mul_ce beat; MUL_LATENCY more cycles
                // let that beat reach mul_acc before SUM samples it.
                if (drain_r == DW'(MUL_LATENCY)) begin
                    next_s = SUM;
                end else begin
                    next_s = DRAIN;
                end
            end
            SUM:     next_s = OUT;
            OUT: begin
                if (out_fire_s) begin
                    if (last_neuron_s) begin
                        next_s = LOAD;
                    end else begin
                        next_s = CLEAR;
                    end
                end else begin
                    next_s = OUT;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Chunk, neuron and drain counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chunk_r  <= {CW{1'b0}};
            neuron_r <= {NW{1'b0}};
            drain_r  <= {DW{1'b0}};
        end else begin
            case (state_r)
                LOAD: begin
                    if (in_fire_s) begin
                        chunk_r <= last_chunk_s ? {CW{1'b0}} : chunk_r + CW'(1);
                    end else begin
                        chunk_r <= chunk_r;
                    end
                end
                CLEAR:   chunk_r <= {CW{1'b0}};
                COMPUTE: chunk_r <= last_chunk_s ? {CW{1'b0}} : chunk_r + CW'(1);
                default: chunk_r <= chunk_r;
            endcase
            if (out_fire_s) begin
                neuron_r <= last_neuron_s ? {NW{1'b0}} : neuron_r + NW'(1);
            end else begin
                neuron_r <= neuron_r;
            end
            if (state_r == DRAIN) begin
                drain_r <= drain_r + DW'(1);
            end else begin
                drain_r <= {DW{1'b0}};
            end
        end
    end

    // Control outputs registered from the upcoming state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            w_rd_en_r   <= 1'b0;
            mul_ce_r    <= 1'b0;
            mul_rst_r   <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            in_ready_r  <= (next_s == LOAD);
            w_rd_en_r   <= (next_s == COMPUTE);
            // Weight data arrives one cycle after the read strobe.
            mul_ce_r    <= w_rd_en_r;
            mul_rst_r   <= (next_s == CLEAR);
            out_valid_r <= (next_s == OUT);
            out_last_r  <= (next_s == OUT) && last_neuron_s;
        end
    end

    // Sample buffer; contents are don't-care until a full sample has been loaded.
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            buf_r[chunk_r] <= in_features;
        end else begin
            buf_r[chunk_r] <= buf_r[chunk_r];
        end
    end

    // Registered buffer read so features meet the weights returned by the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_r <= {CHW{1'b0}};
        end else if (state_r == COMPUTE) begin
            feat_r <= buf_r[chunk_r];
        end else begin
            feat_r <= feat_r;
        end
    end

    lane_reducer #(
        .LANES (MUL_PER_FEATURE),
        .WIDTH (BIAS_PRECISION)
    ) u_lane_reducer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_r == SUM),
        .lanes  (mul_acc),
        .result (out_data)
    );

    assign w_addr       = AW'(neuron_r) * AW'(NUM_CHUNKS) + AW'(chunk_r);
    assign in_ready     = in_ready_r;
    assign w_rd_en      = w_rd_en_r;
    assign mul_ce       = mul_ce_r;
    assign mul_rst      = mul_rst_r;
    assign mul_features = feat_r;
    assign mul_weights  = w_rd_data;
    assign out_valid    = out_valid_r;
    assign out_last     = out_last_r;

endmodule

// File: tb/tb_linear_layer_scheduler.sv
// Self-checking bench for linear_layer_scheduler with a behavioural weight memory
// and multiplier array (one product per lane, MUL_LATENCY beat-to-accumulator delay).
module tb_linear_layer_scheduler;

    localparam int NF = 4, P = 8, BP = 32, MPF = 4, NC = 2, NN = 2, ML = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [NF*P-1:0]     in_features = '0;
    logic [1:0]          w_addr;
    logic                w_rd_en;
    logic [NF*P-1:0]     w_rd_data;
    logic                mul_rst;
    logic                mul_ce;
    logic [NF*P-1:0]     mul_features;
    logic [NF*P-1:0]     mul_weights;
    logic [MPF*BP-1:0]   mul_acc;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [BP-1:0]       out_data;
    logic                out_last;

    always #5 clk = ~clk;

    linear_layer_scheduler #(
        .NUM_FEATURES(NF), .PRECISION(P), .BIAS_PRECISION(BP), .MUL_PER_FEATURE(MPF),
        .NUM_CHUNKS(NC), .NUM_NEURONS(NN), .MUL_LATENCY(ML)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_features(in_features), .w_addr(w_addr), .w_rd_en(w_rd_en), .w_rd_data(w_rd_data),
        .mul_rst(mul_rst), .mul_ce(mul_ce), .mul_features(mul_features), .mul_weights(mul_weights),
        .mul_acc(mul_acc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    // Weight memory, one-cycle read latency.
    logic [NF*P-1:0] wmem [NN*NC];
    always @(posedge clk) if (w_rd_en) w_rd_data <= wmem[w_addr];

    function automatic int prod(input logic [7:0] a, input logic [7:0] b);
        logic signed [7:0] sa, sb;
        int x, y;
        sa = a; sb = b; x = sa; y = sb;
        return x * y;
    endfunction

    // Multiplier array model: beat at cycle t is visible in the accumulators at t+ML.
    int   pipe_p [ML-1][MPF];
    logic pipe_v [ML-1];
    int   acc_m  [MPF];
    always @(posedge clk) begin
        if (mul_rst) begin
            for (int s = 0; s < ML-1; s++) pipe_v[s] <= 1'b0;
            for (int l = 0; l < MPF; l++) acc_m[l] <= 0;
        end else begin
            pipe_v[0] <= mul_ce;
            for (int i = 0; i < NF; i++) pipe_p[0][i] <= prod(mul_features[i*P +: P], mul_weights[i*P +: P]);
            for (int s = 1; s < ML-1; s++) begin
                pipe_v[s] <= pipe_v[s-1];
                pipe_p[s] <= pipe_p[s-1];
            end
            if (pipe_v[ML-2]) for (int l = 0; l < MPF; l++) acc_m[l] <= acc_m[l] + pipe_p[ML-2][l];
        end
    end

    logic            acc_force = 1'b0;
    logic [MPF*BP-1:0] force_val = '0;
    assign mul_acc = acc_force ? force_val : {acc_m[3], acc_m[2], acc_m[1], acc_m[0]};

    typedef struct packed { logic [31:0] data; logic last; } exp_t;
    exp_t sb[$];

    int errors = 0, checks = 0, cyc = 0, ce_total = 0;
    int t_seen [NN];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mul_ce === 1'b1) ce_total <= ce_total + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] calc(input logic [31:0] c0, input logic [31:0] c1, input int n);
        int s;
        logic [31:0] ch, w;
        s = 0;
        for (int k = 0; k < NC; k++) begin
            ch = (k == 0) ? c0 : c1;
            w  = wmem[n*NC + k];
            for (int i = 0; i < NF; i++) s += prod(ch[i*P +: P], w[i*P +: P]);
        end
`ifdef LINEAR_SCHED_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic set_w(input int n, input logic [7:0] v);
        for (int k = 0; k < NC; k++) wmem[n*NC + k] = {4{v}};
    endtask

    // Push expectations, then offer the two chunks (optionally valid every other cycle).
    task automatic send_sample(input logic [31:0] c0, input logic [31:0] c1, input bit toggle,
                               input bit forced, input logic [31:0] fval);
        int acc_n;
        exp_t e;
        for (int n = 0; n < NN; n++) begin
            e.data = forced ? fval : calc(c0, c1, n);
            e.last = (n == NN-1);
            sb.push_back(e);
        end
        acc_n = 0;
        for (int i = 0; i < 100 && acc_n < NC; i++) begin
            @(negedge clk);
            in_valid    = toggle ? ((i % 2) == 0) : 1'b1;
            in_features = in_valid ? ((acc_n == 0) ? c0 : c1) : 32'hEEEE_EEEE;
            if (in_valid && in_ready) acc_n++;
        end
        check("chunks_accepted", acc_n, NC);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Collect NN results; optionally hold out_ready low for 20 cycles on neuron 0.
    task automatic collect(input bit stall);
        exp_t e;
        logic [31:0] held;
        int bad;
        for (int n = 0; n < NN; n++) begin
            out_ready = !(stall && n == 0);
            for (int k = 0; k < 200 && out_valid !== 1'b1; k++) @(negedge clk);
            check("out_valid_seen", {31'b0, out_valid}, 32'd1);
            in_valid  = 1'b0;
            t_seen[n] = cyc;
            if (stall && n == 0) begin
                held = out_data;
                bad  = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (!(out_valid === 1'b1 && out_data === held && mul_ce === 1'b0 &&
                          w_rd_en === 1'b0 && out_last === 1'b0)) bad++;
                end
                check("stall_hold", bad, 0);
                out_ready = 1'b1;
            end
            e.data = 32'hxxxx_xxxx;
            e.last = 1'bx;
            if (sb.size() > 0) e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_last", {31'b0, out_last}, {31'b0, e.last});
            @(negedge clk);
        end
    endtask

    initial begin
        int ce_start, extra;
        logic [31:0] neg_exp, ovf_exp;
`ifdef LINEAR_SCHED_RELU_EN
        neg_exp = 32'd0;
        ovf_exp = 32'd0;
`else
        neg_exp = 32'hFFFF_FFE8;
        ovf_exp = 32'h8000_0000;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_w_rd_en", {31'b0, w_rd_en}, 32'd0);
        check("rst_mul_ce", {31'b0, mul_ce}, 32'd0);
        check("rst_mul_rst", {31'b0, mul_rst}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;

        // 1: features 1, weights 2 -> 16, 16; 9 cycles per neuron; NC beats per neuron
        set_w(0, 8'd2); set_w(1, 8'd2);
        ce_start = ce_total;
        send_sample(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 32'd0);
        collect(1'b0);
        check("cycles_per_neuron", t_seen[1] - t_seen[0], 32'd9);
        check("mul_ce_beats", ce_total - ce_start, NN*NC);

        // 2: neuron0 weights -3, neuron1 weights 5
        set_w(0, 8'hFD); set_w(1, 8'd5);
        check("model_neg", calc(32'h0101_0101, 32'h0101_0101, 0), neg_exp);
        send_sample(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 32'd0);
        collect(1'b0);

        // 3: out_ready held low 20 cycles in OUT
        set_w(0, 8'd2); set_w(1, 8'd2);
        send_sample(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 32'd0);
        collect(1'b1);

        // 4: in_valid toggling while loading, then in_valid held high while computing
        set_w(0, 8'd1); set_w(1, 8'd1);
        send_sample(32'h0101_0101, 32'h0202_0202, 1'b1, 1'b0, 32'd0);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_features = 32'hEEEE_EEEE;
            if (in_valid && in_ready) extra++;
        end
        check("ignored_in_valid", extra, 0);
        collect(1'b0);

        // 5: reset pulse during COMPUTE, then a fresh sample
        set_w(0, 8'd2); set_w(1, 8'd2);
        send_sample(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 50 && w_rd_en !== 1'b1; k++) @(negedge clk);
        check("compute_reached", {31'b0, w_rd_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_w_rd_en", {31'b0, w_rd_en}, 32'd0);
        check("mid_rst_mul_ce", {31'b0, mul_ce}, 32'd0);
        check("mid_rst_mul_rst", {31'b0, mul_rst}, 32'd1);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_sample(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 32'd0);
        collect(1'b0);

        // 6: lane sum overflow wraps (or clamps to zero)
        force_val = {32'h0, 32'h0, 32'h1, 32'h7FFF_FFFF};
        acc_force = 1'b1;
        send_sample(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b1, ovf_exp);
        collect(1'b0);
        acc_force = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
